// File: rtl/pipe_controller.sv
// Control unit for a 5-stage pipeline: decode, ID/EX, EX/MEM, MEM/WB control registers,
// hazard stalls, branch flushes and an ECALL halt FSM. Define FORWARD_EN for EX forwarding.
module pipe_controller #(
    parameter int unsigned DM_BYTES = 4,
    parameter int unsigned REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [4:0]          id_opcode,
    input  logic [2:0]          id_func3,
    input  logic                id_func7,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                ex_branch_taken,
    output logic                stall,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                next_pc_sel,
    output logic                ex_alu_src1_sel,
    output logic                ex_alu_src2_sel,
    output logic                ex_jb_src1_sel,
    output logic [1:0]          fwd_rs1_sel,
    output logic [1:0]          fwd_rs2_sel,
    output logic [DM_BYTES-1:0] mem_dm_w_en,
    output logic                wb_en,
    output logic                wb_sel,
    output logic [REG_AW-1:0]   wb_rd,
    output logic                halt
);

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpRI     = 5'b00100;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpRR     = 5'b01100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpEcall  = 5'b11100;

    typedef struct packed {
        logic                wb_en;
        logic                wb_sel;
        logic                alu_src1;
        logic                alu_src2;
        logic                jb_src1;
        logic                is_load;
        logic                is_jump;
        logic                is_branch;
        logic                is_ecall;
        logic [DM_BYTES-1:0] dm_w_en;
        logic [REG_AW-1:0]   rd;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
    } ex_ctrl_t;

    typedef struct packed {
        logic                wb_en;
        logic                wb_sel;
        logic                is_load;
        logic                is_ecall;
        logic [DM_BYTES-1:0] dm_w_en;
        logic [REG_AW-1:0]   rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic              wb_en;
        logic              wb_sel;
        logic [REG_AW-1:0] rd;
    } wb_ctrl_t;

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    ex_ctrl_t  dec, idex_d, idex_q;
    mem_ctrl_t exmem_d, exmem_q;
    wb_ctrl_t  memwb_d, memwb_q;
    state_e    state_q;
    logic      halt_q;

    logic                rs1_used, rs2_used, wb_req;
    logic [DM_BYTES-1:0] store_be;
    logic                flush, hazard, ld_use;

    logic unused_func7;
    assign unused_func7 = id_func7;

    function automatic logic src_hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
        return (rd != '0) && ((rd == a) || (rd == b));
    endfunction

    always_comb begin
        store_be = '0;
        case (id_func3)
            3'b000:  store_be = DM_BYTES'(8'h01);
            3'b001:  store_be = DM_BYTES'(8'h03);
            3'b010:  store_be = DM_BYTES'(8'h0F);
            3'b011:  store_be = (DM_BYTES == 8) ? DM_BYTES'(8'hFF) : '0;
            default: store_be = '0;
        endcase
    end

    always_comb begin
        dec      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        wb_req   = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OpLoad:   begin wb_req = 1'b1; dec.wb_sel = 1'b1; dec.is_load = 1'b1;
                                rs1_used = 1'b1; end
                OpRI:     begin wb_req = 1'b1; rs1_used = 1'b1; end
                OpAuipc:  begin wb_req = 1'b1; dec.alu_src1 = 1'b1; end
                OpStore:  begin rs1_used = 1'b1; rs2_used = 1'b1; dec.dm_w_en = store_be; end
                OpRR:     begin wb_req = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                                dec.alu_src2 = 1'b1; end
                OpLui:    wb_req = 1'b1;
                OpBranch: begin rs1_used = 1'b1; rs2_used = 1'b1; dec.alu_src2 = 1'b1;
                                dec.is_branch = 1'b1; end
                OpJalr:   begin wb_req = 1'b1; rs1_used = 1'b1; dec.alu_src1 = 1'b1;
                                dec.jb_src1 = 1'b1; dec.is_jump = 1'b1; end
                OpJal:    begin wb_req = 1'b1; dec.alu_src1 = 1'b1; dec.is_jump = 1'b1; end
                OpEcall:  dec.is_ecall = 1'b1;
                default:  ;
            endcase
        end
        // Unused sources and non-writing rd are zeroed so x0 comparisons never hit.
        dec.wb_en = wb_req && (id_rd != '0);
        dec.rd    = dec.wb_en ? id_rd : '0;
        dec.rs1   = rs1_used ? id_rs1 : '0;
        dec.rs2   = rs2_used ? id_rs2 : '0;
    end

    assign flush  = idex_q.is_jump || (idex_q.is_branch && ex_branch_taken);
    assign ld_use = idex_q.is_load && src_hit(idex_q.rd, dec.rs1, dec.rs2);

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input mem_ctrl_t m,
                                           input wb_ctrl_t w);
        if (rs == '0)                                  return 2'b00;
        else if (m.wb_en && !m.is_load && m.rd == rs)  return 2'b01;
        else if (w.wb_en && w.rd == rs)                return 2'b10;
        else                                           return 2'b00;
    endfunction

    assign hazard      = ld_use;
    assign fwd_rs1_sel = fwd_sel(idex_q.rs1, exmem_q, memwb_q);
    assign fwd_rs2_sel = fwd_sel(idex_q.rs2, exmem_q, memwb_q);
`else
    // Write-through register file: only ID/EX and EX/MEM producers must be waited on.
    assign hazard = ld_use
                 || (idex_q.wb_en && src_hit(idex_q.rd, dec.rs1, dec.rs2))
                 || (exmem_q.wb_en && src_hit(exmem_q.rd, dec.rs1, dec.rs2));
    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;

    logic unused_fwd;
    assign unused_fwd = ^{idex_q.rs1, idex_q.rs2, exmem_q.is_load};
`endif

    assign stall  = (state_q != StRun) || (hazard && !flush);
    assign idex_d = (flush || stall) ? '0 : dec;

    always_comb begin
        exmem_d          = '0;
        exmem_d.wb_en    = idex_q.wb_en;
        exmem_d.wb_sel   = idex_q.wb_sel;
        exmem_d.is_load  = idex_q.is_load;
        exmem_d.is_ecall = idex_q.is_ecall;
        exmem_d.dm_w_en  = idex_q.dm_w_en;
        exmem_d.rd       = idex_q.rd;
        memwb_d          = '0;
        memwb_d.wb_en    = exmem_q.wb_en;
        memwb_d.wb_sel   = exmem_q.wb_sel;
        memwb_d.rd       = exmem_q.rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Halt FSM: the committed ECALL is in EX/MEM on the DRAIN->HALT edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                StRun:   if (idex_d.is_ecall) state_q <= StDrain;
                StDrain: if (exmem_q.is_ecall) begin
                    state_q <= StHalt;
                    halt_q  <= 1'b1;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StRun;
            endcase
        end
    end

    assign flush_ifid      = flush;
    assign flush_idex      = flush;
    assign next_pc_sel     = flush;
    assign ex_alu_src1_sel = idex_q.alu_src1;
    assign ex_alu_src2_sel = idex_q.alu_src2;
    assign ex_jb_src1_sel  = idex_q.jb_src1;
    assign mem_dm_w_en     = exmem_q.dm_w_en;
    assign wb_en           = memwb_q.wb_en;
    assign wb_sel          = memwb_q.wb_sel;
    assign wb_rd           = memwb_q.rd;
    assign halt            = halt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed, table-driven bench for pipe_controller (default and 8-byte store builds).
module tb_pipe_controller;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [4:0] LD = 5'b00000, RI = 5'b00100, AU = 5'b00101, ST = 5'b01000;
    localparam logic [4:0] RR = 5'b01100, LU = 5'b01101, BR = 5'b11000, JR = 5'b11001;
    localparam logic [4:0] JL = 5'b11011, EC = 5'b11100, XX = 5'b11111;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_func7, ex_branch_taken;
    logic [4:0] id_opcode, id_rs1, id_rs2, id_rd;
    logic [2:0] id_func3;

    logic       stall, flush_ifid, flush_idex, next_pc_sel;
    logic       ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [3:0] mem_dm_w_en;
    logic       wb_en, wb_sel, halt;
    logic [4:0] wb_rd;

    logic       s8_stall, s8_fi, s8_fe, s8_npc, s8_a1, s8_a2, s8_jb, s8_we, s8_ws, s8_halt;
    logic [1:0] s8_f1, s8_f2;
    logic [7:0] mem_dm_w_en8;
    logic [4:0] s8_rd;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_controller dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func3(id_func3), .id_func7(id_func7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(stall),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .next_pc_sel(next_pc_sel),
        .ex_alu_src1_sel(ex_alu_src1_sel), .ex_alu_src2_sel(ex_alu_src2_sel),
        .ex_jb_src1_sel(ex_jb_src1_sel), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .mem_dm_w_en(mem_dm_w_en), .wb_en(wb_en), .wb_sel(wb_sel), .wb_rd(wb_rd), .halt(halt)
    );

    pipe_controller #(.DM_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func3(id_func3), .id_func7(id_func7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(s8_stall),
        .flush_ifid(s8_fi), .flush_idex(s8_fe), .next_pc_sel(s8_npc),
        .ex_alu_src1_sel(s8_a1), .ex_alu_src2_sel(s8_a2), .ex_jb_src1_sel(s8_jb),
        .fwd_rs1_sel(s8_f1), .fwd_rs2_sel(s8_f2), .mem_dm_w_en(mem_dm_w_en8),
        .wb_en(s8_we), .wb_sel(s8_ws), .wb_rd(s8_rd), .halt(s8_halt)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rs1, rs2, rd;
        logic       bt;
        logic       st, fl, a1, a2, jb;
        logic [3:0] dm4;
        logic [7:0] dm8;
        logic       we, ws;
        logic [4:0] wrd;
        logic       hlt;
    } vec_t;

    function automatic logic [30:0] outs();
        return {stall, flush_ifid, flush_idex, next_pc_sel, ex_alu_src1_sel, ex_alu_src2_sel,
                ex_jb_src1_sel, fwd_rs1_sel, fwd_rs2_sel, mem_dm_w_en, mem_dm_w_en8,
                wb_en, wb_sel, wb_rd, halt};
    endfunction

    function automatic logic [30:0] ex(input logic st, fl, a1, a2, jb, input logic [1:0] f1, f2,
                                       input logic [3:0] dm4, input logic [7:0] dm8,
                                       input logic we, ws, input logic [4:0] wrd,
                                       input logic hlt);
        return {st, fl, fl, fl, a1, a2, jb, f1, f2, dm4, dm8, we, ws, wrd, hlt};
    endfunction

    task automatic check(input string name, input logic [30:0] got, input logic [30:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, got, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic f7, input logic [4:0] s1, s2, d, input logic bt);
        id_valid = v; id_opcode = op; id_func3 = f3; id_func7 = f7;
        id_rs1 = s1; id_rs2 = s2; id_rd = d; ex_branch_taken = bt;
    endtask

    task automatic idle();
        drive(N, 5'd0, 3'd0, N, 5'd0, 5'd0, 5'd0, N);
    endtask

    vec_t tbl [29];

    initial begin
        // {v,op,f3,f7,rs1,rs2,rd,bt | stall,flush,a1,a2,jb,dm4,dm8,wb_en,wb_sel,wb_rd,halt}
        tbl[0]  = '{Y, RR, 3'd0, N, 5'd1,  5'd2,  5'd3,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[1]  = '{Y, ST, 3'd0, N, 5'd10, 5'd11, 5'd7,  N, N, N, N, Y, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[2]  = '{Y, ST, 3'd1, N, 5'd12, 5'd13, 5'd0,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[3]  = '{Y, ST, 3'd2, N, 5'd12, 5'd13, 5'd0,  N, N, N, N, N, N, 4'h1, 8'h01, Y, N, 5'd3, N};
        tbl[4]  = '{Y, ST, 3'd3, N, 5'd12, 5'd13, 5'd0,  N, N, N, N, N, N, 4'h3, 8'h03, N, N, 5'd0, N};
        tbl[5]  = '{Y, LU, 3'd0, N, 5'd31, 5'd31, 5'd8,  N, N, N, N, N, N, 4'hF, 8'h0F, N, N, 5'd0, N};
        tbl[6]  = '{Y, AU, 3'd0, N, 5'd31, 5'd31, 5'd9,  N, N, N, N, N, N, 4'h0, 8'hFF, N, N, 5'd0, N};
        tbl[7]  = '{Y, RI, 3'd0, N, 5'd1,  5'd0,  5'd0,  N, N, N, Y, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[8]  = '{Y, XX, 3'd0, N, 5'd9,  5'd8,  5'd5,  N, N, N, N, N, N, 4'h0, 8'h00, Y, N, 5'd8, N};
        tbl[9]  = '{N, LD, 3'd2, N, 5'd9,  5'd8,  5'd5,  N, N, N, N, N, N, 4'h0, 8'h00, Y, N, 5'd9, N};
        tbl[10] = '{Y, LD, 3'd2, N, 5'd1,  5'd0,  5'd5,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[11] = '{Y, RR, 3'd0, N, 5'd5,  5'd1,  5'd6,  N, Y, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[12] = '{Y, RR, 3'd0, N, 5'd5,  5'd1,  5'd6,  N, Y, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[13] = '{Y, RR, 3'd0, N, 5'd5,  5'd1,  5'd6,  N, N, N, N, N, N, 4'h0, 8'h00, Y, Y, 5'd5, N};
        tbl[14] = '{Y, RR, 3'd0, Y, 5'd6,  5'd2,  5'd4,  N, Y, N, N, Y, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[15] = '{Y, RR, 3'd0, Y, 5'd6,  5'd2,  5'd4,  N, Y, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[16] = '{Y, RR, 3'd0, Y, 5'd6,  5'd2,  5'd4,  N, N, N, N, N, N, 4'h0, 8'h00, Y, N, 5'd6, N};
        tbl[17] = '{Y, LD, 3'd2, N, 5'd2,  5'd0,  5'd7,  N, N, N, N, Y, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[18] = '{Y, BR, 3'd0, N, 5'd1,  5'd2,  5'd0,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[19] = '{Y, RR, 3'd0, N, 5'd7,  5'd1,  5'd6,  Y, N, Y, N, Y, N, 4'h0, 8'h00, Y, N, 5'd4, N};
        tbl[20] = '{Y, BR, 3'd0, N, 5'd1,  5'd2,  5'd0,  N, N, N, N, N, N, 4'h0, 8'h00, Y, Y, 5'd7, N};
        tbl[21] = '{Y, JL, 3'd0, N, 5'd7,  5'd7,  5'd1,  N, N, N, N, Y, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[22] = '{Y, EC, 3'd0, N, 5'd0,  5'd0,  5'd0,  N, N, Y, Y, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[23] = '{Y, JR, 3'd0, N, 5'd3,  5'd0,  5'd2,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[24] = '{Y, RI, 3'd0, N, 5'd2,  5'd0,  5'd10, N, N, Y, Y, N, Y, 4'h0, 8'h00, Y, N, 5'd1, N};
        tbl[25] = '{Y, EC, 3'd0, N, 5'd0,  5'd0,  5'd0,  N, N, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[26] = '{Y, RR, 3'd0, N, 5'd1,  5'd2,  5'd11, N, Y, N, N, N, N, 4'h0, 8'h00, Y, N, 5'd2, N};
        tbl[27] = '{Y, RR, 3'd0, N, 5'd1,  5'd2,  5'd11, N, Y, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, N};
        tbl[28] = '{Y, RR, 3'd0, N, 5'd1,  5'd2,  5'd11, N, Y, N, N, N, N, 4'h0, 8'h00, N, N, 5'd0, Y};

        rst = 1'b1;
        drive(Y, RR, 3'd0, N, 5'd1, 5'd2, 5'd3, Y);
        @(negedge clk);
        check("reset", outs(), 31'd0);
        idle();
        rst = 1'b0;

`ifndef FORWARD_EN
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].bt);
            #1;
            check($sformatf("row%0d", i), outs(),
                  ex(tbl[i].st, tbl[i].fl, tbl[i].a1, tbl[i].a2, tbl[i].jb, 2'b00, 2'b00,
                     tbl[i].dm4, tbl[i].dm8, tbl[i].we, tbl[i].ws, tbl[i].wrd, tbl[i].hlt));
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(Y, RR, 3'd0, N, 5'd1, 5'd2, 5'd3, N);
            #1;
            check($sformatf("halt_hold%0d", i), outs(),
                  ex(Y, N, N, N, N, 2'b00, 2'b00, 4'h0, 8'h00, N, N, 5'd0, Y));
        end

        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        check("rst_in_halt", outs(), 31'd0);
        #1 rst = 1'b0;
`else
        @(negedge clk);
        drive(Y, LD, 3'd2, N, 5'd1, 5'd0, 5'd5, N);
        #1 check("fw_load", outs(), 31'd0);
        @(negedge clk);
        drive(Y, RR, 3'd0, N, 5'd5, 5'd1, 5'd6, N);
        #1 check("fw_lu_stall", outs(), ex(Y, N, N, N, N, 2'b00, 2'b00, 4'h0, 8'h00, N, N, 5'd0, N));
        @(negedge clk);
        #1 check("fw_lu_bubble", outs(), 31'd0);
        @(negedge clk);
        drive(Y, RR, 3'd0, N, 5'd6, 5'd0, 5'd7, N);
        #1 check("fw_memwb", outs(), ex(N, N, N, Y, N, 2'b10, 2'b00, 4'h0, 8'h00, Y, Y, 5'd5, N));
        @(negedge clk);
        idle();
        #1 check("fw_exmem", outs(), ex(N, N, N, Y, N, 2'b01, 2'b00, 4'h0, 8'h00, N, N, 5'd0, N));
        repeat (3) @(negedge clk);
`endif

        @(negedge clk);
        drive(Y, EC, 3'd0, N, 5'd0, 5'd0, 5'd0, N);
        #1 check("ecall_id", outs(), 31'd0);
        @(negedge clk);
        idle();
        #1 check("drain_stall", outs(), ex(Y, N, N, N, N, 2'b00, 2'b00, 4'h0, 8'h00, N, N, 5'd0, N));
        #1 rst = 1'b1;
        #1 check("rst_in_drain", outs(), 31'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(Y, RR, 3'd0, N, 5'd1, 5'd2, 5'd3, N);
        #1 check("post_rst", outs(), 31'd0);
        @(negedge clk);
        idle();
        #1 check("post_rst_ex", outs(), ex(N, N, N, Y, N, 2'b00, 2'b00, 4'h0, 8'h00, N, N, 5'd0, N));
        repeat (2) @(negedge clk);
        #1 check("post_rst_wb", outs(), ex(N, N, N, N, N, 2'b00, 2'b00, 4'h0, 8'h00, Y, N, 5'd3, N));
        repeat (3) @(negedge clk);
        #1 check("no_halt", outs(), 31'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter DM_BYTES, default 4, meaning the data-memory byte-enable width; legal values are 4 and 8.
REQ-002 SHALL have parameter REG_AW, default 5, meaning the register-address width.
REQ-003 SHALL have ports, one per line, as follows:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_opcode  in  5  inst[6:2].
- id_func3  in  3  inst[14:12].
- id_func7  in  1  inst[30].
- id_rs1, id_rs2, id_rd  in  REG_AW each  register fields of the ID instruction.
- ex_branch_taken  in  1  ALU branch compare result for the EX instruction.
- stall  out  1  hold PC and IF/ID.
- flush_ifid, flush_idex  out  1 each  squash IF/ID and ID/EX respectively.
- next_pc_sel  out  1  1 selects the jump/branch target.
- ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel  out  1 each  EX-stage operand selects.
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- mem_dm_w_en  out  DM_BYTES  MEM-stage byte write enables.
- wb_en, wb_sel  out  1 each  WB-stage write enable; 1 selects load data.
- wb_rd  out  REG_AW  WB destination register.
- halt  out  1  core halted after ECALL retires.

Function
REQ-004 SHALL use opcodes LOAD 00000, R_I 00100, AUIPC 00101, STORE 01000, R_R 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, ECALL 11100; any other opcode decodes as a bubble, and all control bits are 0.
REQ-005 SHALL decode in ID and carry control through registered ID/EX, EX/MEM and MEM/WB stages, so each control field appears one cycle per stage after ID.
REQ-006 SHALL set wb_en for R_R, R_I, LOAD, JALR, LUI, AUIPC and JAL only, and SHALL force it to 0 when rd=0.
REQ-007 SHALL set alu_src1_sel=1 (PC) for AUIPC/JAL/JALR, alu_src2_sel=1 (rs2) for R_R/BRANCH, jb_src1_sel=1 for JALR, and wb_sel=1 for LOAD.
REQ-008 SHALL set mem_dm_w_en for STORE only: func3 000 gives 0x01, 001 gives 0x03, 010 gives 0x0F, and 011 gives 0xFF only when DM_BYTES=8; all other cases give 0.
REQ-009 SHALL treat rs1 as used by R_R, R_I, LOAD, STORE, BRANCH and JALR, and rs2 as used by R_R, STORE and BRANCH; register x0 never creates a hazard.
REQ-010 SHALL assert next_pc_sel, flush_ifid and flush_idex combinationally when EX holds JAL, JALR, or BRANCH with ex_branch_taken=1.
REQ-011 SHALL detect a load-use hazard when ID/EX holds a LOAD whose rd equals a used ID source; it SHALL then assert stall and load a bubble into ID/EX for exactly 1 cycle.
REQ-012 SHALL give flush priority over stall when both occur in the same cycle: stall is deasserted and the flush is applied.
REQ-013 SHALL have a halt FSM with states RUN, DRAIN and HALT:
- RUN goes to DRAIN when an ECALL is written into ID/EX without being flushed.
- DRAIN asserts stall continuously and goes to HALT when that ECALL reaches MEM/WB, 2 cycles later.
- HALT asserts halt=1 and stall=1 until reset.
- An ECALL removed by a flush has no effect.
REQ-014 SHALL treat id_valid=0 as a bubble: no hazard is raised and no control is issued.

Reset
REQ-015 SHALL, while rst=1, asynchronously clear all pipeline control registers to the bubble value, set the FSM to RUN, and drive every output to 0.
REQ-016 SHALL, when rst is asserted mid-drain, abandon the drain, and SHALL issue no write on the first edge after rst deasserts.

Configuration
REQ-017 SHALL, with FORWARD_EN defined, produce forwarding selects as follows:
- fwd_rsX_sel=01 when EX/MEM wb_en=1, its rd equals the EX source and it is not a LOAD.
- Otherwise fwd_rsX_sel=10 when MEM/WB wb_en=1 and its rd matches.
- EX/MEM takes priority over MEM/WB.
- Only load-use hazards stall.
REQ-018 SHALL, with FORWARD_EN undefined, tie fwd_rs1_sel and fwd_rs2_sel to 00 and stall while a used ID source matches the wb_en rd in ID/EX or in EX/MEM; the register file is write-through, so MEM/WB matches need no stall.

Verification
REQ-019 SHALL cover load-use: LOAD x5 followed by ADD x6,x5,x1 -> stall=1 for exactly 1 cycle, a bubble in EX, and fwd_rs1_sel=10 on the ADD (FORWARD_EN).
REQ-020 SHALL cover a taken branch: BEQ in EX with ex_branch_taken=1 and a LOAD stall in the same cycle -> next_pc_sel=flush_ifid=flush_idex=1 and stall=0.
REQ-021 SHALL cover store widths: SB/SH/SW -> mem_dm_w_en 0x01/0x03/0x0F; SD with DM_BYTES=8 -> 0xFF; SD with DM_BYTES=4 -> 0x00.
REQ-022 SHALL cover halt: ECALL enters ID/EX -> stall=1 from the next cycle and halt=1 two cycles later, persisting for 10+ cycles; a flushed ECALL never raises halt.
REQ-023 SHALL cover no-forwarding mode: FORWARD_EN undefined, ADD x3 followed by SUB x4,x3,x2 -> stall=1 for 2 cycles and fwd_rs1_sel=00.
REQ-024 SHALL cover reset during DRAIN: rst pulsed in DRAIN -> all outputs 0 immediately, then normal issue resumes with halt=0.
